wb_burst_master: RTL and testbench

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master_pkg.sv | 16 +
 rtl/wb_burst_master.sv | 147 ++++++++++++++
 tb/tb_wb_burst_master.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_pkg.sv
// Shared Wishbone cycle-type / burst-type codes and the burst master FSM encoding.
// Every Wishbone block in this slice imports its CTI/BTE codes from here.
package wb_burst_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master: takes one command (we/adr/len), streams
// len+1 words over the bus, then reports done/err for one cycle before going idle.
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int ADDRESS = 9,
  parameter int WIDTH   = 32,
  parameter int LBITS   = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  // command
  input  logic                 cmd_req_i,
  output logic                 cmd_gnt_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRESS-1:0]   cmd_adr_i,
  input  logic [LBITS-1:0]     cmd_len_i,
  // write data
  input  logic                 wdat_valid_i,
  input  logic [WIDTH-1:0]     wdat_i,
  input  logic [WIDTH/8-1:0]   wsel_i,
  output logic                 wdat_take_o,
  // read data
  output logic                 rdat_valid_o,
  output logic [WIDTH-1:0]     rdat_o,
  output logic [WIDTH/8-1:0]   rsel_o,
  // status
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           dbg_state_o,
  // wishbone master
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  output logic [ADDRESS-1:0]   wb_adr_o,
  output logic [WIDTH/8-1:0]   wb_sel_o,
  output logic [WIDTH-1:0]     wb_dat_o,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic [WIDTH/8-1:0]   wb_sel_i,
  input  logic [WIDTH-1:0]     wb_dat_i
);

  // Handshakes: cmd_gnt_o is a same-cycle accept of cmd_req_i (only in IDLE);
  // wdat_take_o / rdat_valid_o pulse exactly in the cycle a bus word completes
  // (stb & ack & !err); an error aborts with no data strobe for that word.

  state_t               state, state_nxt;
  logic                 we_q, we_nxt;
  logic [ADDRESS-1:0]   adr_q, adr_nxt;
  logic [LBITS-1:0]     rem_q, rem_nxt;   // words remaining minus one
  logic                 err_q, err_nxt;

  logic in_idle, in_burst, in_done;
  logic stb, last_word, xfer_ok, xfer_err;

  assign in_idle  = (state == ST_IDLE);
  assign in_burst = (state == ST_BURST);
  assign in_done  = (state == ST_DONE);

  // Write bursts insert master wait states whenever the data source is empty.
  assign stb       = in_burst & (we_q ? wdat_valid_i : 1'b1);
  assign last_word = (rem_q == '0);
  assign xfer_err  = stb & wb_err_i;
  assign xfer_ok   = stb & wb_ack_i & ~wb_err_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= ST_IDLE;
      we_q  <= 1'b0;
      adr_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      we_q  <= we_nxt;
      adr_q <= adr_nxt;
      rem_q <= rem_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    we_nxt    = we_q;
    adr_nxt   = adr_q;
    rem_nxt   = rem_q;
    err_nxt   = err_q;
    case (state)
      ST_IDLE: begin
        if (cmd_req_i) begin
          state_nxt = ST_BURST;
          we_nxt    = cmd_we_i;
          adr_nxt   = cmd_adr_i;
          rem_nxt   = cmd_len_i;
          err_nxt   = 1'b0;
        end
      end
      ST_BURST: begin
        if (xfer_err) begin
          state_nxt = ST_DONE;
          err_nxt   = 1'b1;
        end else if (xfer_ok) begin
          // Address wraps naturally at 2^ADDRESS.
          adr_nxt = adr_q + ADDRESS'(1);
          if (last_word) begin
            state_nxt = ST_DONE;
          end else begin
            rem_nxt = rem_q - LBITS'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant is combinational, so it is gated by reset explicitly.
  assign cmd_gnt_o    = in_idle & cmd_req_i & wb_rst_ni;

  assign wb_cyc_o     = in_burst;
  assign wb_stb_o     = stb;
  assign wb_we_o      = in_burst & we_q;
  assign wb_cti_o     = in_burst ? (last_word ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
  assign wb_bte_o     = BTE_LINEAR;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = wdat_i;
  assign wb_sel_o     = wsel_i;

  assign wdat_take_o  = xfer_ok & we_q;
  assign rdat_valid_o = xfer_ok & ~we_q;
  assign rdat_o       = wb_dat_i;
  assign rsel_o       = wb_sel_i;

  assign busy_o       = in_burst | in_done;
  assign done_o       = in_done;
  assign err_o        = err_q;
  assign dbg_state_o  = state;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: write/read bursts, wait states, address
// wrap, error abort, ack+err collision, held request and mid-burst reset.
module tb_wb_burst_master;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LB = 4;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_ni;
  logic            cmd_req_i, cmd_we_i;
  logic            cmd_gnt_o;
  logic [AW-1:0]   cmd_adr_i;
  logic [LB-1:0]   cmd_len_i;
  logic            wdat_valid_i;
  logic [DW-1:0]   wdat_i;
  logic [DW/8-1:0] wsel_i;
  logic            wdat_take_o;
  logic            rdat_valid_o;
  logic [DW-1:0]   rdat_o;
  logic [DW/8-1:0] rsel_o;
  logic            busy_o, done_o, err_o;
  logic [1:0]      dbg_state_o;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_i, wb_err_i;
  logic [DW/8-1:0] wb_sel_i;
  logic [DW-1:0]   wb_dat_i;

  int total = 0;
  int bad   = 0;
  int pulses;

  wb_burst_master #(.ADDRESS(AW), .WIDTH(DW), .LBITS(LB)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_req_i(cmd_req_i), .cmd_gnt_o(cmd_gnt_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wdat_valid_i(wdat_valid_i), .wdat_i(wdat_i), .wsel_i(wsel_i),
    .wdat_take_o(wdat_take_o),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .rsel_o(rsel_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .dbg_state_o(dbg_state_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Inputs are driven 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cyc"},   64'(wb_cyc_o),     64'd0);
    chk({tag, "_stb"},   64'(wb_stb_o),     64'd0);
    chk({tag, "_we"},    64'(wb_we_o),      64'd0);
    chk({tag, "_cti"},   64'(wb_cti_o),     64'd0);
    chk({tag, "_adr"},   64'(wb_adr_o),     64'd0);
    chk({tag, "_done"},  64'(done_o),       64'd0);
    chk({tag, "_err"},   64'(err_o),        64'd0);
    chk({tag, "_busy"},  64'(busy_o),       64'd0);
    chk({tag, "_gnt"},   64'(cmd_gnt_o),    64'd0);
    chk({tag, "_take"},  64'(wdat_take_o),  64'd0);
    chk({tag, "_rval"},  64'(rdat_valid_o), 64'd0);
  endtask

  initial begin
    wb_rst_ni = 1'b0;
    cmd_req_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
    wdat_valid_i = 1'b0; wdat_i = '0; wsel_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_sel_i = '0; wb_dat_i = '0;
    cmd_req_i = 1'b1;                       // request during reset must not grant
    #3;
    chk_idle_outputs("rst");
    chk("rst_bte", 64'(wb_bte_o), 64'd0);
    chk("rst_state", 64'(dbg_state_o), 64'd0);
    cmd_req_i = 1'b0;
    tick();
    wb_rst_ni = 1'b1;
    tick();

    // ---- write, len=1, adr=0, always valid, zero-wait slave ----
    cmd_req_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 9'h000; cmd_len_i = 4'd1;
    wdat_valid_i = 1'b1; wdat_i = 32'hA5A5_0001; wsel_i = 4'hF; wb_ack_i = 1'b1;
    settle();
    chk("w1_gnt", 64'(cmd_gnt_o), 64'd1);
    chk("w1_gnt_cyc", 64'(wb_cyc_o), 64'd0);
    chk("w1_gnt_stb_ack_ignored", 64'(wdat_take_o), 64'd0);
    tick();
    cmd_req_i = 1'b0;
    settle();
    chk("w1_c1_cyc", 64'(wb_cyc_o), 64'd1);
    chk("w1_c1_stb", 64'(wb_stb_o), 64'd1);
    chk("w1_c1_we", 64'(wb_we_o), 64'd1);
    chk("w1_c1_cti", 64'(wb_cti_o), 64'h2);
    chk("w1_c1_adr", 64'(wb_adr_o), 64'h000);
    chk("w1_c1_take", 64'(wdat_take_o), 64'd1);
    chk("w1_c1_dat", 64'(wb_dat_o), 64'hA5A5_0001);
    chk("w1_c1_sel", 64'(wb_sel_o), 64'hF);
    chk("w1_c1_busy", 64'(busy_o), 64'd1);
    chk("w1_c1_state", 64'(dbg_state_o), 64'd1);
    tick();
    wdat_i = 32'hA5A5_0002; wsel_i = 4'h3;
    settle();
    chk("w1_c2_cti", 64'(wb_cti_o), 64'h7);
    chk("w1_c2_adr", 64'(wb_adr_o), 64'h001);
    chk("w1_c2_take", 64'(wdat_take_o), 64'd1);
    chk("w1_c2_sel", 64'(wb_sel_o), 64'h3);
    tick();
    settle();
    chk("w1_c3_done", 64'(done_o), 64'd1);
    chk("w1_c3_cyc", 64'(wb_cyc_o), 64'd0);
    chk("w1_c3_stb", 64'(wb_stb_o), 64'd0);
    chk("w1_c3_busy", 64'(busy_o), 64'd1);
    chk("w1_c3_err", 64'(err_o), 64'd0);
    chk("w1_c3_take", 64'(wdat_take_o), 64'd0);
    tick();
    settle();
    chk("w1_c4_done", 64'(done_o), 64'd0);
    chk("w1_c4_busy", 64'(busy_o), 64'd0);

    // ---- write, len=3, adr=0x10, data gap on the second stb-cycle ----
    cmd_req_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 9'h010; cmd_len_i = 4'd3;
    wdat_valid_i = 1'b1;
    settle();
    chk("w2_gnt", 64'(cmd_gnt_o), 64'd1);
    tick();
    cmd_req_i = 1'b0;
    settle();
    chk("w2_c1_adr", 64'(wb_adr_o), 64'h010);
    chk("w2_c1_take", 64'(wdat_take_o), 64'd1);
    tick();
    wdat_valid_i = 1'b0;
    settle();
    chk("w2_c2_stb", 64'(wb_stb_o), 64'd0);
    chk("w2_c2_cyc", 64'(wb_cyc_o), 64'd1);
    chk("w2_c2_adr", 64'(wb_adr_o), 64'h011);
    chk("w2_c2_take", 64'(wdat_take_o), 64'd0);
    tick();
    wdat_valid_i = 1'b1;
    settle();
    chk("w2_c3_adr", 64'(wb_adr_o), 64'h011);
    chk("w2_c3_take", 64'(wdat_take_o), 64'd1);
    chk("w2_c3_cti", 64'(wb_cti_o), 64'h2);
    tick();
    settle();
    chk("w2_c4_adr", 64'(wb_adr_o), 64'h012);
    chk("w2_c4_cti", 64'(wb_cti_o), 64'h2);
    tick();
    settle();
    chk("w2_c5_adr", 64'(wb_adr_o), 64'h013);
    chk("w2_c5_cti", 64'(wb_cti_o), 64'h7);
    chk("w2_c5_take", 64'(wdat_take_o), 64'd1);
    tick();
    settle();
    chk("w2_c6_done", 64'(done_o), 64'd1);
    chk("w2_c6_cyc", 64'(wb_cyc_o), 64'd0);
    tick();

    // ---- read, len=15, adr=0x1F8: address wraps, EOB only on word 16 ----
    cmd_req_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 9'h1F8; cmd_len_i = 4'd15;
    wdat_valid_i = 1'b0; wb_ack_i = 1'b1;
    settle();
    chk("r1_gnt", 64'(cmd_gnt_o), 64'd1);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cmd_req_i = 1'b0;
      wb_dat_i = 32'hD000_0000 + 32'(i);
      wb_sel_i = 4'(i);
      settle();
      if (rdat_valid_o) pulses++;
      chk($sformatf("r1_w%0d_adr", i), 64'(wb_adr_o), 64'((9'h1F8 + 9'(i)) & 9'h1FF));
      chk($sformatf("r1_w%0d_cti", i), 64'(wb_cti_o), (i == 15) ? 64'h7 : 64'h2);
      chk($sformatf("r1_w%0d_dat", i), 64'(rdat_o), 64'hD000_0000 + 64'(i));
      chk($sformatf("r1_w%0d_rsel", i), 64'(rsel_o), 64'(i));
      chk($sformatf("r1_w%0d_stb", i), 64'(wb_stb_o), 64'd1);
    end
    chk("r1_pulses", 64'(pulses), 64'd16);
    tick();
    settle();
    chk("r1_done", 64'(done_o), 64'd1);
    chk("r1_rval_after", 64'(rdat_valid_o), 64'd0);
    chk("r1_adr_after", 64'(wb_adr_o), 64'h008);
    tick();

    // ---- read, len=3, slave errors on word 2 ----
    cmd_req_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 9'h020; cmd_len_i = 4'd3;
    wb_ack_i = 1'b0; wb_err_i = 1'b1;      // err while stb=0 is ignored
    settle();
    chk("e1_gnt", 64'(cmd_gnt_o), 64'd1);
    tick();
    cmd_req_i = 1'b0; wb_ack_i = 1'b1; wb_err_i = 1'b0;
    settle();
    chk("e1_w1_rval", 64'(rdat_valid_o), 64'd1);
    chk("e1_w1_err", 64'(err_o), 64'd0);
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b1;
    settle();
    chk("e1_w2_rval", 64'(rdat_valid_o), 64'd0);
    chk("e1_w2_adr", 64'(wb_adr_o), 64'h021);
    tick();
    wb_err_i = 1'b0;
    settle();
    chk("e1_cyc_low", 64'(wb_cyc_o), 64'd0);
    chk("e1_stb_low", 64'(wb_stb_o), 64'd0);
    chk("e1_done", 64'(done_o), 64'd1);
    chk("e1_err", 64'(err_o), 64'd1);
    chk("e1_state", 64'(dbg_state_o), 64'd2);
    tick();
    settle();
    chk("e1_idle_done", 64'(done_o), 64'd0);
    chk("e1_err_hold", 64'(err_o), 64'd1);

    // ---- request held high; ack+err together takes the abort path ----
    cmd_req_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 9'h030; cmd_len_i = 4'd2;
    wb_ack_i = 1'b1;
    settle();
    chk("h1_gnt", 64'(cmd_gnt_o), 64'd1);
    chk("h1_err_until_gnt", 64'(err_o), 64'd1);
    tick();
    settle();
    chk("h1_w1_no_gnt", 64'(cmd_gnt_o), 64'd0);
    chk("h1_w1_err_clr", 64'(err_o), 64'd0);
    chk("h1_w1_rval", 64'(rdat_valid_o), 64'd1);
    tick();
    wb_err_i = 1'b1;
    settle();
    chk("h1_w2_rval", 64'(rdat_valid_o), 64'd0);
    chk("h1_w2_no_gnt", 64'(cmd_gnt_o), 64'd0);
    tick();
    wb_err_i = 1'b0;
    // next command: write len=7 at 0x40, granted on the return to IDLE
    cmd_we_i = 1'b1; cmd_adr_i = 9'h040; cmd_len_i = 4'd7;
    wdat_valid_i = 1'b1; wdat_i = 32'h1234_5678; wsel_i = 4'hF;
    settle();
    chk("h1_done", 64'(done_o), 64'd1);
    chk("h1_err", 64'(err_o), 64'd1);
    chk("h1_done_no_gnt", 64'(cmd_gnt_o), 64'd0);
    chk("h1_cyc_low", 64'(wb_cyc_o), 64'd0);
    tick();
    settle();
    chk("h1_regnt", 64'(cmd_gnt_o), 64'd1);

    // ---- reset during word 3 of an 8-word write ----
    tick();
    cmd_req_i = 1'b0;
    settle();
    chk("x1_w1_adr", 64'(wb_adr_o), 64'h040);
    tick();
    settle();
    chk("x1_w2_adr", 64'(wb_adr_o), 64'h041);
    tick();
    settle();
    chk("x1_w3_adr", 64'(wb_adr_o), 64'h042);
    chk("x1_w3_cyc", 64'(wb_cyc_o), 64'd1);
    wb_rst_ni = 1'b0;
    #1;
    chk_idle_outputs("x1_rst");
    chk("x1_rst_state", 64'(dbg_state_o), 64'd0);
    tick();
    settle();
    chk("x1_rst_hold_cyc", 64'(wb_cyc_o), 64'd0);
    tick();
    wb_rst_ni = 1'b1;
    cmd_req_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 9'h055; cmd_len_i = 4'd0;
    wdat_valid_i = 1'b0; wb_dat_i = 32'hCAFE_F00D;
    settle();
    chk("x1_post_gnt", 64'(cmd_gnt_o), 64'd1);
    chk("x1_post_cyc", 64'(wb_cyc_o), 64'd0);
    tick();
    cmd_req_i = 1'b0;
    settle();
    chk("x1_single_adr", 64'(wb_adr_o), 64'h055);
    chk("x1_single_cti", 64'(wb_cti_o), 64'h7);
    chk("x1_single_rval", 64'(rdat_valid_o), 64'd1);
    chk("x1_single_dat", 64'(rdat_o), 64'hCAFE_F00D);
    tick();
    settle();
    chk("x1_single_done", 64'(done_o), 64'd1);
    chk("x1_single_cyc", 64'(wb_cyc_o), 64'd0);
    chk("x1_single_err", 64'(err_o), 64'd0);
    tick();
    settle();
    chk("x1_final_busy", 64'(busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
